iot_data_tx: RTL and testbench

Byte-serial transmitter that feeds the IoT data-filter core. It accepts 128-bit sensor words from an upstream producer through a valid/ready handshake and buffers them in a small FIFO. It serializes each word MSB byte first onto the filter's 8-bit `iot_in`/`in_en` input, stalling whenever the core raises `busy`. It drives the core's `fn_sel` for a run of a programmed number of 8-word rounds and pulses `done` when the run is fully delivered.

---
 rtl/iot_data_tx.sv | 160 ++++++++++++++++
 tb/tb_iot_data_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iot_data_tx.sv
// rtl/iot_data_tx.sv - byte-serial word transmitter feeding the IoT data-filter core
module iot_data_tx #(
  parameter int WORD_W          = 128,
  parameter int BYTE_W          = 8,
  parameter int WORDS_PER_ROUND = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    fn_cfg,
  input  logic [7:0]                    num_rounds,
  input  logic                          wr_valid,
  input  logic [WORD_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          busy,
  output logic                          in_en,
  output logic [BYTE_W-1:0]             iot_in,
  output logic [2:0]                    fn_sel,
  output logic                          tx_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BPW   = WORD_W / BYTE_W;
  localparam int BC_W  = $clog2(BPW);
  localparam int WL_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WL_W-1:0]     words_left_q, words_left_d;
  logic [2:0]          fn_sel_q, fn_sel_d;
  logic                zero_done_q, zero_done_d;

  logic                full, empty, push, pop;
  logic [WORD_W-1:0]   head;

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = wr_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign wr_ready   = !full;
  assign fifo_count = count_q;
  assign fn_sel     = fn_sel_q;
  assign tx_active  = (state_q == S_WAIT) || (state_q == S_SEND);
  assign done       = (state_q == S_DONE) || zero_done_q;

  // FIFO storage: written on push, no reset needed since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state, shift register and run counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      fn_sel_q     <= '0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      fn_sel_q     <= fn_sel_d;
      zero_done_q  <= zero_done_d;
    end
  end

  // Next-state and byte strobe; a stalled byte is re-presented until busy falls
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    fn_sel_d     = fn_sel_q;
    zero_done_d  = 1'b0;
    pop          = 1'b0;
    in_en        = 1'b0;
    iot_in       = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rounds != 8'd0) begin
            fn_sel_d     = fn_cfg;
            words_left_d = WL_W'(num_rounds) * WL_W'(WORDS_PER_ROUND);
            state_d      = S_WAIT;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_d    = head;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        in_en  = !busy;
        iot_in = shreg_q[WORD_W-1 -: BYTE_W];
        if (!busy) begin
          shreg_d    = shreg_q << BYTE_W;
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (byte_cnt_q == BC_W'(BPW - 1)) begin
            words_left_d = words_left_q - WL_W'(1);
            if (words_left_q == WL_W'(1)) begin
              state_d = S_DONE;
            end else if (!empty) begin
              pop        = 1'b1;
              shreg_d    = head;
              byte_cnt_d = '0;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iot_data_tx.sv
// tb/tb_iot_data_tx.sv - directed self-checking bench for iot_data_tx
module tb_iot_data_tx;

  localparam logic [127:0] W0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam int NW = 18;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   fn_cfg;
  logic [7:0]   num_rounds;
  logic         wr_valid;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         tx_active;
  logic [2:0]   fifo_count;
  logic         done;

  int n_cmp;
  int n_err;
  int strobe_cnt;
  int push_idx;
  int push_limit;
  logic [127:0] words [NW];

  iot_data_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fn_cfg     (fn_cfg),
    .num_rounds (num_rounds),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .fn_sel     (fn_sel),
    .tx_active  (tx_active),
    .fifo_count (fifo_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // advance one cycle; tracks pushes made by the feeder and strobes seen by the core
  task automatic step();
    logic pushed;
    pushed = wr_valid && wr_ready;
    if (in_en === 1'b1) strobe_cnt++;
    @(negedge clk);
    if (pushed) push_idx++;
    wr_valid = (push_idx < push_limit);
    wr_data  = (push_idx < NW) ? words[push_idx] : '0;
  endtask

  function automatic logic [7:0] exp_byte(input int k, input int b);
    logic [127:0] w;
    w = words[k];
    return w[127-8*b -: 8];
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; strobe_cnt = 0; push_idx = 0; push_limit = 0;
    for (int i = 0; i < NW; i++) words[i] = W0 ^ {16{8'(i * 27)}};
    rst = 1'b0; start = 1'b0; fn_cfg = '0; num_rounds = '0;
    wr_valid = 1'b0; wr_data = '0; busy = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_en", in_en, 0);
    chk("rst_iot_in", iot_in, 0);
    chk("rst_fn_sel", fn_sel, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // FIFO full while idle: four pushes fill it, the fifth word waits
    push_limit = 5;
    wr_valid = 1'b1;
    wr_data  = words[0];
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fill_count_%0d", i), fifo_count, i + 1);
    end
    chk("full_wr_ready", wr_ready, 0);
    step();
    step();
    chk("full_count_hold", fifo_count, 4);
    chk("full_idle_in_en", in_en, 0);

    // basic run: one round, fn 3
    push_limit = 8;
    start = 1'b1; fn_cfg = 3'd3; num_rounds = 8'd1;
    step();
    start = 1'b0;
    chk("wait_tx_active", tx_active, 1);
    chk("wait_in_en", in_en, 0);
    chk("wait_fn_sel", fn_sel, 3);
    step();
    chk("pop_count", fifo_count, 3);
    strobe_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 16; b++) begin
        if (k == 0 && b == 5) begin
          busy = 1'b1;
          #1;
          for (int j = 0; j < 3; j++) begin
            chk($sformatf("stall_in_en_%0d", j), in_en, 0);
            chk($sformatf("stall_iot_in_%0d", j), iot_in, 8'h55);
            step();
          end
          busy = 1'b0;
          #1;
        end
        chk($sformatf("run_in_en_w%0d_b%0d", k, b), in_en, 1);
        chk($sformatf("run_byte_w%0d_b%0d", k, b), iot_in, exp_byte(k, b));
        if (k == 2 && b == 3) begin
          start = 1'b1; fn_cfg = 3'd5; num_rounds = 8'd2;
        end
        step();
        start = 1'b0;
      end
    end
    chk("run_done", done, 1);
    chk("run_done_in_en", in_en, 0);
    chk("run_fn_sel_kept", fn_sel, 3);
    chk("run_strobes", strobe_cnt, 128);
    step();
    chk("run_done_pulse_end", done, 0);
    chk("run_idle_tx_active", tx_active, 0);
    chk("run_fifo_empty", fifo_count, 0);

    // starvation: FIFO empty at start, one word every 30 cycles
    start = 1'b1; fn_cfg = 3'd6; num_rounds = 8'd1;
    step();
    start = 1'b0;
    chk("starve_fn_sel", fn_sel, 6);
    strobe_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      push_limit = push_idx + 1;
      wr_valid = 1'b1;
      wr_data  = words[push_idx];
      step();
      chk($sformatf("starve_wait_in_en_%0d", k), in_en, 0);
      chk($sformatf("starve_wait_active_%0d", k), tx_active, 1);
      step();
      for (int b = 0; b < 16; b++) begin
        chk($sformatf("starve_in_en_w%0d_b%0d", k, b), in_en, 1);
        chk($sformatf("starve_byte_w%0d_b%0d", k, b), iot_in, exp_byte(8 + k, b));
        step();
      end
      if (k < 7) begin
        for (int j = 0; j < 12; j++) begin
          chk($sformatf("starve_gap_active_%0d", k), tx_active, 1);
          chk($sformatf("starve_gap_done_%0d", k), done, 0);
          step();
        end
      end
    end
    chk("starve_done", done, 1);
    chk("starve_strobes", strobe_cnt, 128);
    step();
    chk("starve_done_end", done, 0);

    // zero-round start: immediate done, fn_sel untouched, no strobes
    start = 1'b1; fn_cfg = 3'd2; num_rounds = 8'd0;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_in_en", in_en, 0);
    chk("zero_tx_active", tx_active, 0);
    chk("zero_fn_sel", fn_sel, 6);
    step();
    chk("zero_done_end", done, 0);

    // reset during the 9th byte of a word
    push_limit = push_idx + 2;
    wr_valid = 1'b1;
    wr_data  = words[push_idx];
    step();
    step();
    chk("rmid_prefill", fifo_count, 2);
    start = 1'b1; fn_cfg = 3'd1; num_rounds = 8'd1;
    step();
    start = 1'b0;
    step();
    for (int b = 0; b < 8; b++) step();
    chk("rmid_9th_in_en", in_en, 1);
    chk("rmid_9th_byte", iot_in, exp_byte(16, 8));
    rst = 1'b0;
    #1;
    chk("rmid_in_en", in_en, 0);
    chk("rmid_fifo_count", fifo_count, 0);
    chk("rmid_tx_active", tx_active, 0);
    chk("rmid_done", done, 0);
    step();
    rst = 1'b1;
    chk("rmid_fn_sel", fn_sel, 0);
    chk("rmid_wr_ready", wr_ready, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("rmid_after_done_%0d", j), done, 0);
      chk($sformatf("rmid_after_active_%0d", j), tx_active, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
